// File: rtl/line_buffer_frame_ctrl_pkg.sv
// line_buffer_frame_ctrl_pkg: FSM states, defaults and width helper for the median-filter frame sequencer.
package line_buffer_frame_ctrl_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam int DEF_DW     = 8;
    localparam int DEF_W      = 256;
    localparam int DEF_H      = 256;
    localparam int DEF_LB_LAT = 1;

    // Never returns a zero width, so tiny geometries still get a 1-bit counter.
    function automatic int clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/line_buffer_frame_ctrl_tag.sv
// tag_delay_pipe: DEPTH-stage shift register carrying window tags, synchronously cleared.
module tag_delay_pipe #(
    parameter int DEPTH = 1,
    parameter int DW    = 1
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/line_buffer_frame_ctrl.sv
// line_buffer_frame_ctrl: feeds line_buffer_kernel_3 one frame at a time, pads W+1 pushes at the end
// and emits a row/col/border tag aligned with each centred 3x3 window.
module line_buffer_frame_ctrl
    import line_buffer_frame_ctrl_pkg::*;
#(
    parameter int                   Datawidth = DEF_DW,
    parameter int                   IMG_W     = DEF_W,
    parameter int                   IMG_H     = DEF_H,
    parameter logic [Datawidth-1:0] PAD_VAL   = '0,
    parameter int                   LB_LAT    = DEF_LB_LAT
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       Start,
    input  logic                       In_Valid,
    input  logic [Datawidth-1:0]       In_Data,
    output logic                       In_Ready,
    output logic [Datawidth-1:0]       LB_In,
    output logic                       LB_Valid,
    output logic                       Tag_Valid,
    output logic [clog2(IMG_H)-1:0]    Tag_Row,
    output logic [clog2(IMG_W)-1:0]    Tag_Col,
    output logic                       Tag_Border,
    output logic                       Busy,
    output logic                       Done
);

    localparam int RW = clog2(IMG_H);
    localparam int CW = clog2(IMG_W);
    localparam int PW = clog2(IMG_W * IMG_H + IMG_W + 2);
    localparam int TW = RW + CW + 2;

    state_t                 state_q, state_d;
    logic [PW-1:0]          p_q, p_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic [Datawidth-1:0]   lb_in_q, lb_in_d;
    logic                   lb_valid_q, lb_valid_d;
    logic [TW-1:0]          tag_q, tag_d, tag_out;
    logic                   accept, push, tag_vld, border, col_last;

    assign In_Ready = (state_q == S_FILL) || (state_q == S_RUN);
    assign Busy     = state_q != S_IDLE;
    assign accept   = In_Valid & In_Ready;
    assign push     = accept | (state_q == S_FLUSH);
    // Pushes 0..W only prime the line buffer; every later push completes a centred window.
    assign tag_vld  = push & (state_q != S_FILL);
    assign col_last = col_q == CW'(IMG_W - 1);
    assign border   = (row_q == '0) | (row_q == RW'(IMG_H - 1)) | (col_q == '0) | col_last;
    assign LB_In    = lb_in_q;
    assign LB_Valid = lb_valid_q;
    assign {Tag_Valid, Tag_Row, Tag_Col, Tag_Border} = tag_out;
    assign Done     = (state_q == S_DONE) & Tag_Valid & (Tag_Row == RW'(IMG_H - 1)) & (Tag_Col == CW'(IMG_W - 1));

    always_comb begin
        state_d    = state_q;
        p_d        = push ? p_q + 1'b1 : p_q;
        row_d      = tag_vld && col_last ? row_q + 1'b1 : row_q;
        col_d      = tag_vld ? (col_last ? '0 : col_q + 1'b1) : col_q;
        lb_valid_d = push;
        lb_in_d    = (state_q == S_FLUSH) ? PAD_VAL : (accept ? In_Data : lb_in_q);
        tag_d      = tag_vld ? {1'b1, row_q, col_q, border} : '0;
        case (state_q)
            S_IDLE: begin
                p_d   = '0;
                row_d = '0;
                col_d = '0;
                if (Start) state_d = S_FILL;
            end
            S_FILL:  if (accept && p_q == PW'(IMG_W)) state_d = S_RUN;
            S_RUN:   if (accept && p_q == PW'(IMG_W * IMG_H - 1)) state_d = S_FLUSH;
            S_FLUSH: if (p_q == PW'(IMG_W * IMG_H + IMG_W)) state_d = S_DONE;
            // Hold here until the final tag drains out of the delay pipe.
            S_DONE:  if (Done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            lb_in_q    <= '0;
            lb_valid_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            row_q      <= row_d;
            col_q      <= col_d;
            lb_in_q    <= lb_in_d;
            lb_valid_q <= lb_valid_d;
            tag_q      <= tag_d;
        end
    end

    tag_delay_pipe #(.DEPTH(LB_LAT), .DW(TW)) u_tag_pipe (
        .clk_i (CLK),
        .clr_i (CLR),
        .d_i   (tag_q),
        .q_o   (tag_out)
    );

endmodule

// File: tb/tb_line_buffer_frame_ctrl.sv
// tb_line_buffer_frame_ctrl: directed frames on a 4x3 image, two controllers (LB_LAT 1 and 3) on shared stimulus.
module tb_line_buffer_frame_ctrl;

    logic       clk = 0;
    logic       clr, start, in_v;
    logic [7:0] in_d;
    logic       rdy[2], lb_v[2], tag_v[2], tag_b[2], busy[2], done[2];
    logic [7:0] lb_in[2];
    logic [1:0] tag_r[2], tag_c[2];

    int n_tests = 0, n_fail = 0, cyc = 0, ready_hi;
    int n_tag[2], n_done[2], n_push[2], n_pad[2], pad_bad[2], n_aa[2];
    int lb5[2], first_t[2], last_t[2], done_t[2];
    bit after11[2];

    always #5 clk = ~clk;

    line_buffer_frame_ctrl #(.Datawidth(8), .IMG_W(4), .IMG_H(3), .PAD_VAL(8'd0), .LB_LAT(1)) dut1 (
        .CLK(clk), .CLR(clr), .Start(start), .In_Valid(in_v), .In_Data(in_d), .In_Ready(rdy[0]),
        .LB_In(lb_in[0]), .LB_Valid(lb_v[0]), .Tag_Valid(tag_v[0]), .Tag_Row(tag_r[0]),
        .Tag_Col(tag_c[0]), .Tag_Border(tag_b[0]), .Busy(busy[0]), .Done(done[0]));

    line_buffer_frame_ctrl #(.Datawidth(8), .IMG_W(4), .IMG_H(3), .PAD_VAL(8'd0), .LB_LAT(3)) dut3 (
        .CLK(clk), .CLR(clr), .Start(start), .In_Valid(in_v), .In_Data(in_d), .In_Ready(rdy[1]),
        .LB_In(lb_in[1]), .LB_Valid(lb_v[1]), .Tag_Valid(tag_v[1]), .Tag_Row(tag_r[1]),
        .Tag_Col(tag_c[1]), .Tag_Border(tag_b[1]), .Busy(busy[1]), .Done(done[1]));

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!clr) for (int k = 0; k < 2; k++) begin
            if (lb_v[k]) begin
                n_push[k]++;
                if (after11[k]) begin
                    n_pad[k]++;
                    if (lb_in[k] != 8'd0) pad_bad[k]++;
                end
                if (lb_in[k] == 8'hAA) n_aa[k]++;
                if (lb_in[k] == 8'd5 && lb5[k] < 0) lb5[k] = cyc;
                if (lb_in[k] == 8'd11) after11[k] = 1;
            end
            if (tag_v[k]) begin
                chk($sformatf("lat%0d_tag%0d_row", k, n_tag[k]), int'(tag_r[k]), n_tag[k] / 4);
                chk($sformatf("lat%0d_tag%0d_col", k, n_tag[k]), int'(tag_c[k]), n_tag[k] % 4);
                chk($sformatf("lat%0d_tag%0d_border", k, n_tag[k]), int'(tag_b[k]),
                    int'(n_tag[k] / 4 == 0 || n_tag[k] / 4 == 2 || n_tag[k] % 4 == 0 || n_tag[k] % 4 == 3));
                if (first_t[k] < 0) first_t[k] = cyc;
                last_t[k] = cyc;
                n_tag[k]++;
            end
            if (done[k]) begin
                chk($sformatf("lat%0d_done_tag", k), int'({tag_v[k], tag_r[k], tag_c[k]}), 'b1_10_11);
                n_done[k]++;
                done_t[k] = cyc;
            end
        end
    end

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            n_tag[k] = 0; n_done[k] = 0; n_push[k] = 0; n_pad[k] = 0; pad_bad[k] = 0; n_aa[k] = 0;
            lb5[k] = -1; first_t[k] = -1; last_t[k] = -1; done_t[k] = -2; after11[k] = 0;
        end
        ready_hi = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] px);
        bit ok = 0;
        in_d = px;
        in_v = 1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = rdy[0];
            @(posedge clk); #1;
        end
        if (!ok) chk($sformatf("accept_timeout_px%0d", px), 0, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s_lat%0d_outs", tag, k),
                int'({lb_in[k], lb_v[k], tag_v[k], tag_r[k], tag_c[k], tag_b[k], busy[k], done[k], rdy[k]}), 0);
    endtask

    task automatic run_frame(input string name, input int gap, input bit hold_valid, input bit start_mid);
        clear_stats();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (start_mid && i == 8) start = 1;
            send(8'(i));
            start = 0;
            in_v = (i == 11) && hold_valid;
            in_d = 8'hAA;
            repeat (gap) begin @(posedge clk); #1; end
        end
        if (start_mid) pulse_start();
        for (int t = 0; t < 100 && !(n_done[0] > 0 && n_done[1] > 0); t++) begin
            @(negedge clk);
            if (rdy[0] || rdy[1]) ready_hi++;
            @(posedge clk); #1;
        end
        in_v = 0;
        repeat (3) begin @(posedge clk); #1; end
        if (hold_valid) chk({name, "_ready_in_flush"}, ready_hi, 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_lat%0d_tags", name, k), n_tag[k], 12);
            chk($sformatf("%s_lat%0d_dones", name, k), n_done[k], 1);
            chk($sformatf("%s_lat%0d_pushes", name, k), n_push[k], 17);
            chk($sformatf("%s_lat%0d_pads", name, k), n_pad[k], 5);
            chk($sformatf("%s_lat%0d_pad_val", name, k), pad_bad[k], 0);
            chk($sformatf("%s_lat%0d_stray_push", name, k), n_aa[k], 0);
            chk($sformatf("%s_lat%0d_first_lat", name, k), first_t[k] - lb5[k], k ? 3 : 1);
            chk($sformatf("%s_lat%0d_done_align", name, k), done_t[k], last_t[k]);
            chk($sformatf("%s_lat%0d_idle", name, k), int'(busy[k]), 0);
        end
    endtask

    initial begin
        clr = 1; start = 0; in_v = 0; in_d = 0;
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        clr = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("idle_no_start");
        @(posedge clk); #1;

        run_frame("b2b", 0, 0, 0);
        run_frame("alt", 1, 0, 0);
        run_frame("hold", 0, 1, 0);

        clear_stats();
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'(i));
        in_v = 0;
        clr = 1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("clr_mid");
        chk("clr_mid_done_lat0", n_done[0], 0);
        chk("clr_mid_done_lat1", n_done[1], 0);
        clr = 0;
        @(posedge clk); #1;
        run_frame("after_clr", 0, 0, 0);

        run_frame("start_mid", 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
